// File: rtl/sar_sequencer_if.sv
// Sequencer host handshake plus analogue SAR front-end signals, grouped as one bus.
// master = sequencer side, slave = host/analogue environment side.
interface sar_sequencer_if #(
   parameter int NSTEP = 8
);
   logic             start;
   logic             busy;
   logic [NSTEP-1:0] data_out;
   logic             data_valid;
   logic             cmp_err;
   logic             ms_sar_clock;
   logic             ms_sar_sample;
   logic [NSTEP-1:0] ms_sar_sw;
   logic [NSTEP-1:0] ms_sar_swb;
   logic             ms_sar_dh;
   logic             ms_sar_dl;
   logic             ms_sar_rdy;

   modport master (
      input  start, ms_sar_dh, ms_sar_dl, ms_sar_rdy,
      output busy, data_out, data_valid, cmp_err,
             ms_sar_clock, ms_sar_sample, ms_sar_sw, ms_sar_swb
   );

   modport slave (
      output start, ms_sar_dh, ms_sar_dl, ms_sar_rdy,
      input  busy, data_out, data_valid, cmp_err,
             ms_sar_clock, ms_sar_sample, ms_sar_sw, ms_sar_swb
   );
endinterface

// File: rtl/sar_sequencer.sv
// SAR conversion sequencer; result pulse 2*NSAMPLE+3*NSTEP+2 cycles after the IDLE cycle that sees start.
// No backpressure: start is only sampled in IDLE; ms_sar_rdy low aborts to WAIT_RDY. All outputs are flops.
module sar_sequencer #(
   parameter int NSTEP   = 8,
   parameter int NSAMPLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   sar_sequencer_if.master bus
);
   localparam int CW = $clog2(2*NSAMPLE+1);
   localparam int KW = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   typedef enum logic [2:0] {WAIT_RDY, IDLE, SAMPLE, HOLD, SET, EVAL, CAPT, DONE} state_t;
   state_t state, nxt;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [KW-1:0]    k_q, k_d;
   logic [NSTEP-1:0] res_q, res_d, data_q, data_d, sw_q, sw_d, swb_q, swb_d;
   logic             busy_q, busy_d, vld_q, vld_d, err_q, err_d, clk_q, clk_d, smp_q, smp_d;
   logic             pair_bad, bit_k, last_sample;

   assign pair_bad    = (bus.ms_sar_dh == bus.ms_sar_dl);
   assign bit_k       = bus.ms_sar_dh & ~pair_bad;
   assign last_sample = (cnt_q == CW'(2*NSAMPLE-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_RDY;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (!bus.ms_sar_rdy) begin
         nxt = WAIT_RDY;
      end else begin
         case (state)
            WAIT_RDY: nxt = IDLE;
            IDLE:     nxt = bus.start ? SAMPLE : IDLE;
            SAMPLE:   nxt = last_sample ? HOLD : SAMPLE;
            HOLD:     nxt = SET;
            SET:      nxt = EVAL;
            EVAL:     nxt = CAPT;
            CAPT:     nxt = (k_q == '0) ? DONE : SET;
            DONE:     nxt = IDLE;
            default:  nxt = WAIT_RDY;
         endcase
      end
   end

   // Next values of the output flops are derived from the upcoming state so every output is registered.
   always_comb begin
      cnt_d  = cnt_q;
      k_d    = k_q;
      res_d  = res_q;
      data_d = data_q;
      sw_d   = sw_q;
      swb_d  = swb_q;
      busy_d = busy_q;
      vld_d  = 1'b0;
      err_d  = err_q;
      clk_d  = 1'b0;
      smp_d  = 1'b0;

      if (state == HOLD)                   k_d = KW'(NSTEP-1);
      else if (state == CAPT && k_q != '0) k_d = k_q - KW'(1);

      // Rejected bit drops its vrefp switch in the same edge that the next step's switch closes.
      if (state == CAPT && nxt != WAIT_RDY) begin
         res_d[k_q] = bit_k;
         sw_d[k_q]  = bit_k;
         swb_d[k_q] = ~bit_k;
         if (pair_bad) err_d = 1'b1;
      end

      case (nxt)
         WAIT_RDY: begin
            res_d  = '0;
            sw_d   = '0;
            swb_d  = '0;
            busy_d = 1'b0;
            err_d  = 1'b0;
         end
         IDLE: busy_d = 1'b0;
         SAMPLE: begin
            busy_d = 1'b1;
            smp_d  = 1'b1;
            sw_d   = '0;
            swb_d  = '0;
            if (state != SAMPLE) begin
               cnt_d = '0;
               res_d = '0;
               err_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
            clk_d = ~cnt_d[0];
         end
         HOLD: begin
            sw_d  = '0;
            swb_d = '1;
         end
         SET: begin
            sw_d[k_d]  = 1'b1;
            swb_d[k_d] = 1'b0;
         end
         EVAL, CAPT: clk_d = 1'b1;
         DONE: begin
            busy_d = 1'b0;
            vld_d  = 1'b1;
            data_d = res_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         k_q    <= '0;
         res_q  <= '0;
         data_q <= '0;
         sw_q   <= '0;
         swb_q  <= '0;
         busy_q <= 1'b0;
         vld_q  <= 1'b0;
         err_q  <= 1'b0;
         clk_q  <= 1'b0;
         smp_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         k_q    <= k_d;
         res_q  <= res_d;
         data_q <= data_d;
         sw_q   <= sw_d;
         swb_q  <= swb_d;
         busy_q <= busy_d;
         vld_q  <= vld_d;
         err_q  <= err_d;
         clk_q  <= clk_d;
         smp_q  <= smp_d;
      end
   end

   assign bus.busy          = busy_q;
   assign bus.data_out      = data_q;
   assign bus.data_valid    = vld_q;
   assign bus.cmp_err       = err_q;
   assign bus.ms_sar_clock  = clk_q;
   assign bus.ms_sar_sample = smp_q;
   assign bus.ms_sar_sw     = sw_q;
   assign bus.ms_sar_swb    = swb_q;
endmodule

// File: tb/tb_sar_sequencer.sv
// Directed bench for sar_sequencer with NSTEP=4, NSAMPLE=2; comparator answers are driven per step.
module tb_sar_sequencer;
   localparam int NSTEP   = 4;
   localparam int NSAMPLE = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   pulses = 0;
   logic prev_clk = 1'b0;

   always #5 clk = ~clk;

   sar_sequencer_if #(.NSTEP(NSTEP)) ifc ();

   sar_sequencer #(.NSTEP(NSTEP), .NSAMPLE(NSAMPLE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every-cycle checks: no switch overlap, sampling only with switches open, NSAMPLE pulses per result.
   always @(negedge clk) begin
      chk("sw_swb_overlap", 32'(ifc.ms_sar_sw & ifc.ms_sar_swb), 32'd0);
      if (ifc.ms_sar_sample)
         chk("sample_phase", {ifc.busy, ifc.ms_sar_sw, ifc.ms_sar_swb}, 32'b1_0000_0000);
      if (ifc.ms_sar_sample && ifc.ms_sar_clock && !prev_clk) pulses++;
      if (ifc.data_valid) begin
         chk("sample_pulses", pulses, NSAMPLE);
         pulses = 0;
      end else if (!ifc.busy) begin
         pulses = 0;
      end
      prev_clk = ifc.ms_sar_clock;
   end

   // Starts from a negedge in IDLE; pairs[7:6] answers step k=3, pairs[1:0] answers k=0.
   task automatic run_conv(input logic [7:0] pairs);
      int lat;
      int j;
      lat = -1;
      ifc.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.start = 1'b0;
      chk("acc_busy", ifc.busy, 1);
      chk("acc_err_clear", ifc.cmp_err, 0);
      chk("acc_sample_clock", {ifc.ms_sar_sample, ifc.ms_sar_clock}, 2'b11);
      for (int e = 0; e < 60; e++) begin
         if (e > 0) @(negedge clk);
         if (e == 1) chk("sample_clock_low", ifc.ms_sar_clock, 0);
         if (e == 4) chk("hold_switches", {ifc.ms_sar_sample, ifc.ms_sar_clock, ifc.ms_sar_sw, ifc.ms_sar_swb}, 10'b00_0000_1111);
         if (e == 5) chk("set_msb", {ifc.ms_sar_clock, ifc.ms_sar_sw, ifc.ms_sar_swb}, 9'b0_1000_0111);
         if (e == 6) chk("eval_clock", ifc.ms_sar_clock, 1);
         if (e >= 5 && (e - 5) % 3 == 0 && (e - 5) / 3 < NSTEP) begin
            j = (e - 5) / 3;
            {ifc.ms_sar_dh, ifc.ms_sar_dl} = pairs[7-2*j -: 2];
         end
         if (ifc.data_valid) begin
            lat = e;
            chk("done_busy", ifc.busy, 0);
            break;
         end
      end
      chk("latency", lat, 17);
      @(negedge clk);
      chk("idle_after_done", {ifc.data_valid, ifc.busy, ifc.ms_sar_clock, ifc.ms_sar_sample}, 0);
   endtask

   initial begin
      int vt[3];
      int nv;
      rst_n = 1'b0;
      ifc.start = 1'b0;
      ifc.ms_sar_dh = 1'b0;
      ifc.ms_sar_dl = 1'b0;
      ifc.ms_sar_rdy = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_flags", {ifc.busy, ifc.data_valid, ifc.cmp_err, ifc.ms_sar_clock, ifc.ms_sar_sample}, 0);
      chk("reset_data", {ifc.data_out, ifc.ms_sar_sw, ifc.ms_sar_swb}, 0);

      // Analogue not ready: start must be ignored.
      rst_n = 1'b1;
      ifc.start = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("nordy_busy", ifc.busy, 0);
         chk("nordy_clock", {ifc.ms_sar_clock, ifc.ms_sar_sample}, 0);
      end
      ifc.start = 1'b0;
      ifc.ms_sar_rdy = 1'b1;
      @(negedge clk);

      run_conv(8'b10_01_10_10);
      chk("a_data", ifc.data_out, 4'b1011);
      chk("a_sw_swb", {ifc.ms_sar_sw, ifc.ms_sar_swb}, 8'b1011_0100);
      chk("a_err", ifc.cmp_err, 0);

      run_conv(8'b10_11_01_10);
      chk("b_data", ifc.data_out, 4'b1001);
      chk("b_sw_swb", {ifc.ms_sar_sw, ifc.ms_sar_swb}, 8'b1001_0110);
      chk("b_err", ifc.cmp_err, 1);

      run_conv(8'b01_10_01_10);
      chk("c_data", ifc.data_out, 4'b0101);
      chk("c_err", ifc.cmp_err, 0);

      run_conv(8'b01_10_00_10);
      chk("d_data", ifc.data_out, 4'b0101);
      chk("d_err", ifc.cmp_err, 1);

      // Reset during EVAL of step 1.
      ifc.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (12) @(negedge clk);
      chk("mid_eval_clock", ifc.ms_sar_clock, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_flags", {ifc.busy, ifc.data_valid, ifc.cmp_err, ifc.ms_sar_clock, ifc.ms_sar_sample}, 0);
      chk("mid_reset_data", {ifc.data_out, ifc.ms_sar_sw, ifc.ms_sar_swb}, 0);
      repeat (3) begin
         @(negedge clk);
         chk("mid_reset_no_valid", ifc.data_valid, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_conv(8'b10_10_10_01);
      chk("e_data", ifc.data_out, 4'b1110);
      chk("e_err", ifc.cmp_err, 0);

      // Ready drops mid-sample: abort, keep the last result.
      ifc.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (3) @(negedge clk);
      ifc.ms_sar_rdy = 1'b0;
      @(negedge clk);
      chk("rdy_drop_flags", {ifc.busy, ifc.ms_sar_clock, ifc.ms_sar_sample, ifc.ms_sar_sw, ifc.ms_sar_swb}, 0);
      chk("rdy_drop_data_kept", ifc.data_out, 4'b1110);
      ifc.ms_sar_rdy = 1'b1;
      @(negedge clk);

      // start held high: back-to-back conversions.
      ifc.ms_sar_dh = 1'b1;
      ifc.ms_sar_dl = 1'b0;
      ifc.start = 1'b1;
      nv = 0;
      for (int n = 0; n < 100 && nv < 3; n++) begin
         @(negedge clk);
         if (ifc.data_valid) begin
            vt[nv] = n;
            nv++;
         end
      end
      ifc.start = 1'b0;
      chk("b2b_count", nv, 3);
      if (nv == 3) begin
         chk("b2b_interval1", vt[1] - vt[0], 2*NSAMPLE + 3*NSTEP + 3);
         chk("b2b_interval2", vt[2] - vt[1], 2*NSAMPLE + 3*NSTEP + 3);
      end
      chk("b2b_data", ifc.data_out, 4'b1111);
      repeat (25) @(negedge clk);
      chk("b2b_stopped", ifc.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
